// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: synchronizes the raw pins, decodes 11-bit frames, assembles
// 3-byte stream-mode packets and accumulates clamped screen-space cursor coordinates.
module ps2_mouse_tracker #(
    parameter int H_MAX          = 640,
    parameter int V_MAX          = 480,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       pkt_valid,
    output logic       err,
    output logic [1:0] frame_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [11:0] X_LIM = 12'(H_MAX - 1);
    localparam logic signed [11:0] Y_LIM = 12'(V_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Output contract: pkt_valid and err are single-cycle pulses with no back-pressure;
    // mouse_x/mouse_y/buttons change only in the cycle pkt_valid is high.
    state_t        state;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [1:0]    byte_idx;
    logic [TW-1:0] to_cnt;
    logic          yovf_q, xovf_q, ysign_q, xsign_q, btn_r_q, btn_l_q;
    logic [7:0]    byte1_q;

    logic                fall, bit_in, frame_ok, to_hit;
    logic signed [11:0]  dx, dy, nx, ny;
    logic [9:0]          x_new, y_new;

    assign fall        = clk_sync[2] & ~clk_sync[1];
    assign bit_in      = data_sync[1];
    assign frame_ok    = (^{shreg, parity_bit}) & bit_in;
    assign to_hit      = (to_cnt == TW'(TIMEOUT_CYCLES));
    assign frame_state = state;

    always_comb begin
        dx = xovf_q ? '0 : {{4{xsign_q}}, byte1_q};
        dy = yovf_q ? '0 : {{4{ysign_q}}, shreg};
        nx = $signed({2'b00, mouse_x}) + dx;
        ny = $signed({2'b00, mouse_y}) - dy;   // PS/2 Y is up-positive, screen Y is down-positive
        x_new = nx[9:0];
        y_new = ny[9:0];
        if (nx < 0)          x_new = '0;
        else if (nx > X_LIM) x_new = X_LIM[9:0];
        if (ny < 0)          y_new = '0;
        else if (ny > Y_LIM) y_new = Y_LIM[9:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (fall) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            byte_idx   <= '0;
            yovf_q     <= 1'b0;
            xovf_q     <= 1'b0;
            ysign_q    <= 1'b0;
            xsign_q    <= 1'b0;
            btn_r_q    <= 1'b0;
            btn_l_q    <= 1'b0;
            byte1_q    <= '0;
            mouse_x    <= 10'(X_INIT);
            mouse_y    <= 10'(Y_INIT);
            btn_left   <= 1'b0;
            btn_right  <= 1'b0;
            pkt_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            err       <= 1'b0;
            if (fall) begin
                case (state)
                    S_IDLE: begin
                        bit_cnt <= '0;
                        if (!bit_in) state <= S_DATA;
                    end
                    S_DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_bit <= bit_in;
                        state      <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!frame_ok) begin
                            err      <= 1'b1;
                            byte_idx <= '0;
                        end else begin
                            case (byte_idx)
                                2'd0: begin
                                    // bit3 is always set in a real header; anything else means misalignment
                                    if (!shreg[3]) begin
                                        err <= 1'b1;
                                    end else begin
                                        {yovf_q, xovf_q, ysign_q, xsign_q} <= shreg[7:4];
                                        {btn_r_q, btn_l_q}                 <= shreg[1:0];
                                        byte_idx <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    byte1_q  <= shreg;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    mouse_x   <= x_new;
                                    mouse_y   <= y_new;
                                    btn_left  <= btn_l_q;
                                    btn_right <= btn_r_q;
                                    pkt_valid <= 1'b1;
                                    byte_idx  <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (to_hit) begin
                state    <= S_IDLE;
                byte_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: table vectors, hand-written corner sequences and random
// packets scored against a plain-arithmetic cursor model.
module tb_ps2_mouse_tracker;

    localparam int TO   = 2000;
    localparam int HALF = 8;
    localparam int W    = 22;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] mouse_x, mouse_y;
    logic       btn_left, btn_right, pkt_valid, err;
    logic [1:0] frame_state;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int err_cnt = 0;
    int mx = 320;
    int my = 240;
    logic [W-1:0] exp_q[$];

    typedef struct {
        bit         rst;
        logic [7:0] b0, b1, b2;
        int         ex, ey;
        bit         el, er;
    } vec_t;
    vec_t tbl[6];

    ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .btn_left(btn_left), .btn_right(btn_right),
        .pkt_valid(pkt_valid), .err(err), .frame_state(frame_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (pkt_valid || err) check("pv_err_exclusive", 32'(pkt_valid & err), 0);
            if (err) err_cnt++;
            if (pkt_valid) begin
                pv_cnt++;
                check("pkt_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    check("pkt_outputs", 32'({mouse_x, mouse_y, btn_right, btn_left}), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx = clamp(mx + dx, 639);
        my = clamp(my - dy, 479);
        exp_q.push_back({mx[9:0], my[9:0], b0[1], b0[0]});
    endtask

    // drivers
    task automatic send_byte(input logic [7:0] d, input bit bad_par = 0, input bit bad_stop = 0);
        logic [10:0] bits;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        model_packet(b0, b1, b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        mx = 320;
        my = 240;
        exp_q.delete();
        #1;
        check("async_reset_x", 32'(mouse_x), 320);
        check("async_reset_y", 32'(mouse_y), 240);
        check("async_reset_btn", 32'({btn_right, btn_left}), 0);
        repeat (5) @(posedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        int p0, e0;
        tbl[0] = '{0, 8'h09, 8'h0A, 8'h05, 330, 235, 1, 0};
        tbl[1] = '{0, 8'h3A, 8'hF6, 8'hFB, 320, 240, 0, 1};
        tbl[2] = '{1, 8'h18, 8'h00, 8'h00,  64, 240, 0, 0};
        tbl[3] = '{0, 8'h18, 8'h00, 8'h00,   0, 240, 0, 0};
        tbl[4] = '{0, 8'h28, 8'h00, 8'h00,   0, 479, 0, 0};
        tbl[5] = '{0, 8'h48, 8'h7F, 8'h00,   0, 479, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_x", 32'(mouse_x), 320);
        check("reset_y", 32'(mouse_y), 240);
        check("reset_flags", 32'({btn_right, btn_left, pkt_valid, err}), 0);
        @(negedge clk);
        reset = 1'b1;

        // idle pins: nothing may happen
        repeat (5000) @(posedge clk);
        check("idle_pv", pv_cnt, 0);
        check("idle_err", err_cnt, 0);
        check("idle_x", 32'(mouse_x), 320);
        check("idle_y", 32'(mouse_y), 240);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst) do_reset();
            p0 = pv_cnt;
            send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2);
            check("tbl_pv", pv_cnt - p0, 1);
            check("tbl_x", 32'(mouse_x), tbl[i].ex);
            check("tbl_y", 32'(mouse_y), tbl[i].ey);
            check("tbl_left", 32'(btn_left), 32'(tbl[i].el));
            check("tbl_right", 32'(btn_right), 32'(tbl[i].er));
        end

        // bad parity on byte1 discards the packet
        p0 = pv_cnt; e0 = err_cnt;
        send_byte(8'h08);
        send_byte(8'h01, 1);
        check("parity_err", err_cnt - e0, 1);
        check("parity_no_pv", pv_cnt - p0, 0);
        check("parity_hold_x", 32'(mouse_x), 0);
        send_pkt(8'h08, 8'h01, 8'h00);
        check("after_parity_x", 32'(mouse_x), 1);
        check("after_parity_pv", pv_cnt - p0, 1);

        // bad stop bit
        p0 = pv_cnt; e0 = err_cnt;
        send_byte(8'h08, 0, 1);
        check("stop_err", err_cnt - e0, 1);
        send_pkt(8'h08, 8'h02, 8'h00);
        check("after_stop_x", 32'(mouse_x), 3);

        // misaligned header byte
        p0 = pv_cnt; e0 = err_cnt;
        send_byte(8'h00);
        check("hdr_err", err_cnt - e0, 1);
        send_pkt(8'h08, 8'h05, 8'h00);
        check("after_hdr_x", 32'(mouse_x), 8);
        check("after_hdr_pv", pv_cnt - p0, 1);

        // orphan header then timeout resync
        p0 = pv_cnt; e0 = err_cnt;
        send_byte(8'h08);
        repeat (TO + 200) @(posedge clk);
        send_pkt(8'h08, 8'h02, 8'h00);
        check("timeout_x", 32'(mouse_x), 10);
        check("timeout_pv", pv_cnt - p0, 1);
        check("timeout_no_err", err_cnt - e0, 0);

        // reset between byte1 and byte2
        send_pkt(8'h08, 8'h14, 8'h0A);
        send_byte(8'h08);
        send_byte(8'h05);
        do_reset();
        p0 = pv_cnt;
        send_pkt(8'h08, 8'h03, 8'h00);
        check("post_reset_x", 32'(mouse_x), 323);
        check("post_reset_y", 32'(mouse_y), 240);
        check("post_reset_pv", pv_cnt - p0, 1);

        // random packets against the model
        p0 = pv_cnt; e0 = err_cnt;
        for (int i = 0; i < 30; i++) begin
            send_pkt(8'($urandom_range(0, 255)) | 8'h08, 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
        end
        check("rand_pv", pv_cnt - p0, 30);
        check("rand_no_err", err_cnt - e0, 0);
        check("rand_x", 32'(mouse_x), mx);
        check("rand_y", 32'(mouse_y), my);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
